// File: rtl/harris_pkg.sv
// Types shared by the Harris response window generator and the corner check stage.
package harris_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] resp_t;
  typedef resp_t window_t [0:2][0:2];

endpackage

// File: rtl/response_window_gen_line_buffer.sv
// One image row of storage: single address, combinational read-before-write.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  assign o_rd_data = r_mem[i_addr];

  // Contents are deliberately not reset; rows 0 and 1 are rewritten before use.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/response_window_gen.sv
// Raster-stream 3x3 window generator feeding the corner check stage.
module response_window_gen
  import harris_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = harris_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_sof,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          win_valid,
  output window_t                       window,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          frame_done
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     w_pos_row;
  logic [CW-1:0]     w_pos_col;
  logic              w_row_last;
  logic              w_col_last;
  logic              w_emit;
  logic [DATA_W-1:0] w_old_rd;
  logic [DATA_W-1:0] w_new_rd;
  resp_t             w_column [0:2];

  // sof relocates the pixel being accepted to (0,0) in the same cycle.
  assign w_pos_row  = in_sof ? '0 : r_row;
  assign w_pos_col  = in_sof ? '0 : r_col;
  assign w_row_last = (w_pos_row == ROW_LAST);
  assign w_col_last = (w_pos_col == COL_LAST);
  assign w_emit     = in_valid && (w_pos_row >= RW'(2)) && (w_pos_col >= CW'(2));

  assign w_column[0] = w_old_rd;
  assign w_column[1] = w_new_rd;
  assign w_column[2] = in_data;

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb_old (
    .clk       (clk),
    .i_wr_en   (in_valid),
    .i_addr    (w_pos_col),
    .i_wr_data (w_new_rd),
    .o_rd_data (w_old_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb_new (
    .clk       (clk),
    .i_wr_en   (in_valid),
    .i_addr    (w_pos_col),
    .i_wr_data (in_data),
    .o_rd_data (w_new_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_pos_row + RW'(1);
      end else begin
        r_col <= w_pos_col + CW'(1);
        r_row <= w_pos_row;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      win_valid  <= w_emit;
      frame_done <= in_valid && w_row_last && w_col_last;
      if (w_emit) begin
        out_row <= w_pos_row - RW'(1);
        out_col <= w_pos_col - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          window[i][j] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int unsigned i = 0; i < 3; i++) begin
        window[i][0] <= window[i][1];
        window[i][1] <= window[i][2];
        window[i][2] <= w_column[i];
      end
    end
  end

endmodule

// File: doc/response_window_gen.md
# response_window_gen

Streaming 3x3 window generator that sits directly upstream of the corner check stage. It accepts the Harris response map as a raster-ordered stream of 32-bit signed values, one per accepted cycle. It buffers two previous image rows and presents a registered 3x3 neighbourhood, with the centre pixel's coordinates, each time a full interior window is available. Border pixels never produce a window.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per row (minimum 3)
- IMG_HEIGHT, 480, rows per frame (minimum 3)
- DATA_W, 32, response word width (fixed at 32 for the corner stage)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; asserting 0 clears state immediately
- in_valid  in  1  qualifies in_data; no backpressure
- in_sof  in  1  start of frame; meaningful only with in_valid
- in_data  in  DATA_W  response value, two's complement, passed through unmodified
- win_valid  out  1  one-cycle pulse; window/out_row/out_col valid
- window  out  [0:2][0:2] x DATA_W  3x3 neighbourhood; [1][1] is the centre
- out_row  out  $clog2(IMG_HEIGHT)  centre row
- out_col  out  $clog2(IMG_WIDTH)  centre column
- frame_done  out  1  one-cycle pulse after the last pixel of a frame

## Operation
- Accept happens on any cycle with in_valid=1. Idle cycles change nothing.
- row/col counters track the position of the pixel being accepted:
  - col wraps W-1→0 and increments row.
  - row wraps H-1→0.
  - in_valid & in_sof forces the accepted pixel to (0,0). Counters then continue from (0,1).
- Two line buffers:
  - lb_old holds row r-2.
  - lb_new holds row r-1.
- On accept at (r,c):
  - Read lb_old[c] and lb_new[c] (read-before-write, same cycle).
  - Column vector is {lb_old[c], lb_new[c], in_data}.
  - Write lb_old[c]←lb_new[c] and lb_new[c]←in_data.
- Window registers shift left on accept only:
  - window[i][0]←window[i][1]
  - window[i][1]←window[i][2]
  - window[i][2]←column[i]
- Window orientation:
  - Row index 0 = oldest image row.
  - Column index 0 = leftmost image column.
- Emit when the accepted pixel has r≥2 and c≥2:
  - Next cycle: win_valid=1, out_row=r-1, out_col=c-1.
  - Exactly one window per interior pixel: (H-2)*(W-2) windows per frame.
- No window is emitted when c<2. Stale columns from the previous row therefore never appear inside a valid window.
- Line-buffer contents are not reset. They are never exposed, because emission requires r≥2. After a reset or sof, rows 0 and 1 are rewritten before any use.
- Arithmetic is on counters only. Data is never altered, sign-extended or saturated.

## Timing
- Latency: win_valid rises 1 cycle after the accept of pixel (r+1,c+1).
- frame_done: registered, asserted in the same cycle as the final win_valid of the frame, on the cycle after accepting (H-1,W-1).
- Reset values:
  - win_valid=0, frame_done=0.
  - window all zeros.
  - out_row=0, out_col=0.
  - row/col counters 0.
- Outputs hold their values between emissions. win_valid is never high for two cycles unless two accepts occur on consecutive cycles.
- Reset mid-frame: outputs clear asynchronously. The first accept after release is (0,0).
- sof mid-frame: the partial frame is abandoned with no frame_done. A window already pending from the previous cycle is still emitted.
- sof on the accept that would naturally be (0,0): no effect beyond normal.
- Back-to-back frames with no idle cycles are supported at full rate.

## Structure
- Shared package harris_pkg holds:
  - DATA_W = 32
  - typedef logic [31:0] resp_t
  - typedef resp_t window_t [0:2][0:2] — used by this block and the corner stage
- Sub-module line_buffer: parameterised depth IMG_WIDTH and width DATA_W. Single address, read-before-write, combinational read, write on enable. Instantiated twice (lb_old, lb_new).
- Top level holds the counters, the window shift registers and the emission/frame_done logic.

## Test plan
- W=4,H=4, data 0..15 raster, continuous in_valid:
  - 4 windows at centres (1,1),(1,2),(2,1),(2,2).
  - First window rows {0,1,2},{4,5,6},{8,9,10}, one cycle after pixel 10.
  - frame_done together with the (2,2) window.
- Same frame with random idle cycles (0-3) between accepts: identical 4 windows, no pulses during idle.
- W=5,H=3, two back-to-back frames, data includes 32'hFFFF_FFF0:
  - 3 windows per frame.
  - Negative values unchanged.
  - frame_done exactly twice.
- in_sof asserted on the 7th pixel of a W=4,H=4 frame, then 16 fresh pixels:
  - No frame_done for the aborted frame.
  - 4 windows using only new-frame data.
- reset low for 1 cycle mid-frame (after pixel 9 of 16):
  - All outputs 0 immediately.
  - Next full frame produces the exact scenario-1 output.
- Chained into the corner stage, 5x5 frame of zeros with value 100 at (2,2): isCorner high exactly once, 2 cycles after pixel (3,3) is accepted.
